// File: rtl/hdu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hdu_scoreboard
// Summary  : Valid-bit scoreboard for in-flight long instructions with RAW/WAW
//            hazard detection, multi-port commit, flush and ALU forwarding.
//            Optional perf counters enabled by macro HDU_SB_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hdu_scoreboard #(
    parameter int DEPTH      = 8,
    parameter int NUM_COMMIT = 2,
    parameter int REG_AW     = 5,
    parameter int EXT_W      = 4,
    parameter int BYP_BIT    = 3,
    parameter int ID_W       = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inst_valid_i,
    input  logic [REG_AW-1:0]            rd_addr_i,
    input  logic [REG_AW-1:0]            rs1_addr_i,
    input  logic [REG_AW-1:0]            rs2_addr_i,
    input  logic                         rd_we_i,
    input  logic                         rs1_re_i,
    input  logic                         rs2_re_i,
    input  logic [EXT_W-1:0]             ex_type_i,
    input  logic [NUM_COMMIT-1:0]        commit_valid_i,
    input  logic [NUM_COMMIT*ID_W-1:0]   commit_id_i,
    input  logic                         flush_i,
    output logic                         hazard_stall_o,
    output logic                         alloc_o,
    output logic [ID_W-1:0]              alloc_id_o,
    output logic                         pass_rs1_o,
    output logic                         pass_rs2_o,
    output logic [ID_W:0]                occupancy_o,
    output logic                         busy_o,
`ifdef HDU_SB_PERF_CNT_EN
    output logic [31:0]                  raw_stall_cnt_o,
    output logic [31:0]                  waw_stall_cnt_o,
    output logic [31:0]                  full_stall_cnt_o,
`endif
    output logic                         full_o
);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_has_rd;
    logic [REG_AW-1:0] r_rd  [DEPTH];
    logic [EXT_W-1:0]  r_ext [DEPTH];
    logic              r_byp_vld;
    logic [ID_W-1:0]   r_byp_id;
    logic [ID_W:0]     r_occ;

    logic [DEPTH-1:0]  w_commit_hit;
    logic [DEPTH-1:0]  w_live;
    logic [DEPTH-1:0]  w_raw;
    logic [DEPTH-1:0]  w_waw;
    logic [DEPTH-1:0]  w_byp_mask;
    logic [DEPTH-1:0]  w_raw_masked;
    logic [DEPTH-1:0]  w_alloc_vec;
    logic [ID_W-1:0]   w_free_id;
    logic [ID_W:0]     w_commit_cnt;
    logic              w_any_free;
    logic              w_fwd_en;
    logic              w_raw_stall;
    logic              w_waw_stall;
    logic              w_full_stall;
    logic              w_new_has_rd;

    // Duplicate IDs across ports collapse naturally into one hit bit.
    always_comb begin
        w_commit_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < NUM_COMMIT; k++) begin
                if (commit_valid_i[k] && (commit_id_i[k*ID_W +: ID_W] == ID_W'(i)))
                    w_commit_hit[i] = 1'b1;
            end
        end
    end

    assign w_live = r_valid & ~w_commit_hit;

    always_comb begin
        w_raw = '0;
        w_waw = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_raw[i] = w_live[i] && r_has_rd[i] &&
                       ((rs1_re_i && (rs1_addr_i == r_rd[i])) ||
                        (rs2_re_i && (rs2_addr_i == r_rd[i])));
            w_waw[i] = w_live[i] && r_has_rd[i] && rd_we_i &&
                       (rd_addr_i == r_rd[i]) && (ex_type_i != r_ext[i]);
        end
    end

    assign w_fwd_en     = !ex_type_i[BYP_BIT] && r_byp_vld;
    assign w_byp_mask   = w_fwd_en ? (DEPTH'(1) << r_byp_id) : '0;
    assign w_raw_masked = w_raw & ~w_byp_mask;

    // has_rd implies a non-zero rd, so a zero source can never match here.
    assign pass_rs1_o = inst_valid_i && w_fwd_en && w_live[r_byp_id] && r_has_rd[r_byp_id] &&
                        rs1_re_i && (rs1_addr_i == r_rd[r_byp_id]);
    assign pass_rs2_o = inst_valid_i && w_fwd_en && w_live[r_byp_id] && r_has_rd[r_byp_id] &&
                        rs2_re_i && (rs2_addr_i == r_rd[r_byp_id]);

    // Entries committing this cycle are not free until the next cycle.
    always_comb begin
        w_free_id = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i])
                w_free_id = ID_W'(i);
        end
    end

    assign w_any_free = ~&r_valid;

    always_comb begin
        w_commit_cnt = '0;
        for (int i = 0; i < DEPTH; i++)
            w_commit_cnt = w_commit_cnt + (ID_W+1)'(w_commit_hit[i] & r_valid[i]);
    end

    assign w_raw_stall    = inst_valid_i && (|w_raw_masked);
    assign w_waw_stall    = inst_valid_i && (|w_waw);
    assign w_full_stall   = inst_valid_i && !w_any_free;
    assign hazard_stall_o = w_raw_stall || w_waw_stall || w_full_stall;
    assign alloc_o        = inst_valid_i && !hazard_stall_o && !flush_i;
    assign alloc_id_o     = alloc_o ? w_free_id : '0;
    assign w_alloc_vec    = alloc_o ? (DEPTH'(1) << w_free_id) : '0;
    assign w_new_has_rd   = rd_we_i && (rd_addr_i != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= '0;
            r_byp_vld <= 1'b0;
            r_byp_id  <= '0;
            r_occ     <= '0;
        end else if (flush_i) begin
            r_valid   <= '0;
            r_byp_vld <= 1'b0;
            r_occ     <= '0;
        end else begin
            r_valid <= (r_valid & ~w_commit_hit) | w_alloc_vec;
            r_occ   <= r_occ + (ID_W+1)'(alloc_o) - w_commit_cnt;
            if (alloc_o && !ex_type_i[BYP_BIT] && w_new_has_rd) begin
                r_byp_vld <= 1'b1;
                r_byp_id  <= w_free_id;
            end else if (r_byp_vld && w_commit_hit[r_byp_id]) begin
                r_byp_vld <= 1'b0;
            end
        end
    end

    // Payload is qualified by r_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_o) begin
            r_rd[w_free_id]     <= rd_addr_i;
            r_ext[w_free_id]    <= ex_type_i;
            r_has_rd[w_free_id] <= w_new_has_rd;
        end
    end

    assign occupancy_o = r_occ;
    assign busy_o      = |r_valid;
    assign full_o      = (r_occ == (ID_W+1)'(DEPTH));

`ifdef HDU_SB_PERF_CNT_EN
    logic [31:0] r_raw_cnt;
    logic [31:0] r_waw_cnt;
    logic [31:0] r_full_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raw_cnt  <= '0;
            r_waw_cnt  <= '0;
            r_full_cnt <= '0;
        end else begin
            if (w_raw_stall && (r_raw_cnt != '1))
                r_raw_cnt <= r_raw_cnt + 32'd1;
            if (w_waw_stall && (r_waw_cnt != '1))
                r_waw_cnt <= r_waw_cnt + 32'd1;
            if (w_full_stall && (r_full_cnt != '1))
                r_full_cnt <= r_full_cnt + 32'd1;
        end
    end

    assign raw_stall_cnt_o  = r_raw_cnt;
    assign waw_stall_cnt_o  = r_waw_cnt;
    assign full_stall_cnt_o = r_full_cnt;
`endif

endmodule
`default_nettype wire
